// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, ROM addressing and IF/ID register.
// Handles stall, redirect with flush, and sticky misaligned/out-of-range faults.
module fetch_stage #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int PC_WIDTH      = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic [ADDRESS_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0]    rom_instr,
  input  logic                     stall,
  input  logic                     redirect,
  input  logic [PC_WIDTH-1:0]      redirect_pc,
  output logic                     id_valid,
  output logic [DATA_WIDTH-1:0]    id_instr,
  output logic [PC_WIDTH-1:0]      id_pc,
  output logic [PC_WIDTH-1:0]      id_pc_plus4,
  output logic                     fetch_fault,
  output logic [PC_WIDTH-1:0]      fault_pc
);

  localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h0000_0013);
  localparam logic [PC_WIDTH-1:0]   PC_STEP = PC_WIDTH'(4);

  typedef enum logic {
    S_RUN,
    S_FAULT
  } state_t;

  state_t                r_state;
  state_t                w_state_n;
  logic [PC_WIDTH-1:0]   r_pc;
  logic [PC_WIDTH-1:0]   w_pc_n;
  logic                  r_id_valid;
  logic                  w_id_valid_n;
  logic [DATA_WIDTH-1:0] r_id_instr;
  logic [DATA_WIDTH-1:0] w_id_instr_n;
  logic [PC_WIDTH-1:0]   r_id_pc;
  logic [PC_WIDTH-1:0]   w_id_pc_n;
  logic [PC_WIDTH-1:0]   r_id_pc_plus4;
  logic [PC_WIDTH-1:0]   w_id_pc_plus4_n;
  logic                  r_fault;
  logic                  w_fault_n;
  logic [PC_WIDTH-1:0]   r_fault_pc;
  logic [PC_WIDTH-1:0]   w_fault_pc_n;

  logic                  w_in_range;
  logic                  w_misaligned;
  logic [PC_WIDTH-1:0]   w_pc_plus4;

  // Any set bit above the ROM's byte span means the fetch is out of range.
  assign w_in_range   = (r_pc >> (ADDRESS_WIDTH + 2)) == '0;
  assign w_misaligned = redirect_pc[1:0] != 2'b00;
  assign w_pc_plus4   = r_pc + PC_STEP;

  always_comb begin
    w_state_n       = r_state;
    w_pc_n          = r_pc;
    w_id_valid_n    = r_id_valid;
    w_id_instr_n    = r_id_instr;
    w_id_pc_n       = r_id_pc;
    w_id_pc_plus4_n = r_id_pc_plus4;
    w_fault_n       = r_fault;
    w_fault_pc_n    = r_fault_pc;
    unique case (r_state)
      S_RUN: begin
        if (redirect) begin
          w_id_valid_n = 1'b0;
          w_id_instr_n = NOP;
          if (w_misaligned) begin
            w_state_n    = S_FAULT;
            w_fault_n    = 1'b1;
            w_fault_pc_n = redirect_pc;
          end else begin
            w_pc_n = redirect_pc;
          end
        end else if (!stall) begin
          if (!w_in_range) begin
            w_state_n    = S_FAULT;
            w_fault_n    = 1'b1;
            w_fault_pc_n = r_pc;
            w_id_valid_n = 1'b0;
            w_id_instr_n = NOP;
          end else begin
            w_id_valid_n    = 1'b1;
            w_id_instr_n    = rom_instr;
            w_id_pc_n       = r_pc;
            w_id_pc_plus4_n = w_pc_plus4;
            w_pc_n          = w_pc_plus4;
          end
        end
      end
      S_FAULT: begin
        w_id_valid_n = 1'b0;
        w_id_instr_n = NOP;
        w_fault_n    = 1'b1;
      end
      default: begin
        w_state_n = S_RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_RUN;
      r_pc          <= RESET_PC;
      r_id_valid    <= 1'b0;
      r_id_instr    <= NOP;
      r_id_pc       <= '0;
      r_id_pc_plus4 <= '0;
      r_fault       <= 1'b0;
      r_fault_pc    <= '0;
    end else begin
      r_state       <= w_state_n;
      r_pc          <= w_pc_n;
      r_id_valid    <= w_id_valid_n;
      r_id_instr    <= w_id_instr_n;
      r_id_pc       <= w_id_pc_n;
      r_id_pc_plus4 <= w_id_pc_plus4_n;
      r_fault       <= w_fault_n;
      r_fault_pc    <= w_fault_pc_n;
    end
  end

  assign rom_addr    = r_pc[ADDRESS_WIDTH+1:2];
  assign id_valid    = r_id_valid;
  assign id_instr    = r_id_instr;
  assign id_pc       = r_id_pc;
  assign id_pc_plus4 = r_id_pc_plus4;
  assign fetch_fault = r_fault;
  assign fault_pc    = r_fault_pc;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: sequential fetch, stall, redirect,
// misaligned and out-of-range faults, and reset from every situation.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rom_addr;
  logic [31:0] rom_instr;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic        fetch_fault;
  logic [31:0] fault_pc;

  logic [31:0] rom [32];
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  assign rom_instr = rom[rom_addr];

  fetch_stage dut (
    .clk         (clk),
    .rst         (rst),
    .rom_addr    (rom_addr),
    .rom_instr   (rom_instr),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .id_valid    (id_valid),
    .id_instr    (id_instr),
    .id_pc       (id_pc),
    .id_pc_plus4 (id_pc_plus4),
    .fetch_fault (fetch_fault),
    .fault_pc    (fault_pc)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_id(input string tag, input logic v,
                        input logic [31:0] ins, input logic [31:0] pc);
    chk({tag, ".valid"}, 32'(id_valid), 32'(v));
    chk({tag, ".instr"}, id_instr, ins);
    chk({tag, ".pc"}, id_pc, pc);
    chk({tag, ".pc4"}, id_pc_plus4, pc + 32'd4);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".valid"}, 32'(id_valid), 32'd0);
    chk({tag, ".instr"}, id_instr, NOP);
    chk({tag, ".pc"}, id_pc, 32'd0);
    chk({tag, ".pc4"}, id_pc_plus4, 32'd0);
    chk({tag, ".fault"}, 32'(fetch_fault), 32'd0);
    chk({tag, ".fpc"}, fault_pc, 32'd0);
    chk({tag, ".addr"}, 32'(rom_addr), 32'd0);
  endtask

  task automatic chk_fault(input string tag, input logic [31:0] fpc,
                           input logic [31:0] hold_pc);
    chk({tag, ".fault"}, 32'(fetch_fault), 32'd1);
    chk({tag, ".fpc"}, fault_pc, fpc);
    chk({tag, ".valid"}, 32'(id_valid), 32'd0);
    chk({tag, ".instr"}, id_instr, NOP);
    chk({tag, ".pc"}, id_pc, hold_pc);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rom[i] = 32'h0000_0000;
    rom[0]  = 32'h0010_0513;
    rom[1]  = 32'h0015_0513;
    rom[2]  = 32'h0015_0513;
    rom[3]  = 32'h0015_0513;
    rom[4]  = 32'h0015_0513;
    rom[5]  = 32'h0000_006f;
    rom[30] = 32'hAAAA_0001;
    rom[31] = 32'hBBBB_0002;

    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    step();
    step();
    chk_reset("rst0");

    // sequential fetch
    rst = 1'b0;
    step();
    chk_id("seq0", 1'b1, 32'h0010_0513, 32'h0);
    step();
    chk_id("seq1", 1'b1, 32'h0015_0513, 32'h4);
    step();
    chk_id("seq2", 1'b1, 32'h0015_0513, 32'h8);
    chk("seq2.addr", 32'(rom_addr), 32'd3);

    // stall 3 cycles
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk_id("stall", 1'b1, 32'h0015_0513, 32'h8);
      chk("stall.addr", 32'(rom_addr), 32'd3);
    end
    stall = 1'b0;
    step();
    chk_id("unstall", 1'b1, 32'h0015_0513, 32'hC);

    // redirect during stall
    redirect = 1'b1; redirect_pc = 32'h14; stall = 1'b1;
    step();
    chk_id("bubble", 1'b0, NOP, 32'hC);
    chk("bubble.addr", 32'(rom_addr), 32'd5);
    redirect = 1'b0; stall = 1'b0;
    step();
    chk_id("target", 1'b1, 32'h0000_006f, 32'h14);

    // misaligned redirect -> sticky fault
    redirect = 1'b1; redirect_pc = 32'h6;
    step();
    chk_fault("mis", 32'h6, 32'h14);
    redirect_pc = 32'h0;
    for (int k = 0; k < 4; k++) begin
      stall = k[0];
      step();
      chk_fault("sticky", 32'h6, 32'h14);
      chk("sticky.addr", 32'(rom_addr), 32'd6);
      chk("sticky.pc4", id_pc_plus4, 32'h18);
    end

    // reset out of FAULT
    rst = 1'b1;
    step();
    chk_reset("rstF");
    rst = 1'b0; redirect = 1'b0; stall = 1'b0;
    step();
    chk_id("afterF", 1'b1, 32'h0010_0513, 32'h0);
    step();
    chk_id("afterF1", 1'b1, 32'h0015_0513, 32'h4);

    // reset together with redirect and stall
    rst = 1'b1; redirect = 1'b1; redirect_pc = 32'h10; stall = 1'b1;
    step();
    chk_reset("rstRS");
    rst = 1'b0; redirect = 1'b0; stall = 1'b0;
    step();
    chk_id("afterRS", 1'b1, 32'h0010_0513, 32'h0);

    // run off the end of the ROM
    redirect = 1'b1; redirect_pc = 32'h78;
    step();
    chk_id("r78", 1'b0, NOP, 32'h0);
    redirect = 1'b0;
    step();
    chk_id("f78", 1'b1, 32'hAAAA_0001, 32'h78);
    step();
    chk_id("f7C", 1'b1, 32'hBBBB_0002, 32'h7C);
    chk("f7C.fault", 32'(fetch_fault), 32'd0);
    step();
    chk_fault("oor", 32'h80, 32'h7C);
    step();
    chk_fault("oor2", 32'h80, 32'h7C);

    rst = 1'b1;
    step();
    chk_reset("rstEnd");

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
